gcd_stein: RTL
==============

# gcd_stein

Parametrised binary (Stein) GCD engine with valid/ready handshakes on both sides. It replaces subtract-and-swap iteration with shift/subtract steps: one step per clock, no divider, at most about 2·NBITS steps. It reports an iteration count for performance profiling. It sits between an operand producer and a result consumer in the arithmetic accelerator datapath, and either side may stall.

## Interface
- NBITS, 32, operand and result width (≥2)
- CNT_W, $clog2(2*NBITS+2), width of the step counter
- K_W, $clog2(NBITS+1), width of the common-power-of-two counter (internal)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a_in/b_in valid
- in_ready  out  1  engine accepts operands (high only in IDLE)
- a_in  in  NBITS  operand a, unsigned
- b_in  in  NBITS  operand b, unsigned
- out_valid  out  1  result/cycles valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- result  out  NBITS  gcd(a,b); gcd(0,x)=x, gcd(0,0)=0
- cycles  out  CNT_W  number of RUN-state cycles spent, including the terminating cycle

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, capture a←a_in, b←b_in, k←0, cnt←0, then go to RUN.
- RUN: cnt increments every cycle. Exactly one rule applies per cycle, first match wins:
  1. a==0: result←b<<k, go to DONE.
  2. b==0: result←a<<k, go to DONE.
  3. a==b: result←a<<k, go to DONE.
  4. a even and b even: a←a>>1, b←b>>1, k←k+1.
  5. a even: a←a>>1.
  6. b even: b←b>>1.
  7. Both odd, a>b: a←(a−b)>>1.
  8. Both odd, a<b: b←(b−a)>>1.
- cycles is latched with the incremented cnt on the terminating cycle.
- DONE: out_valid=1. result and cycles are held stable. On out_ready, go to IDLE.
- Arithmetic: all values unsigned NBITS; the subtraction never underflows (the larger operand minus the smaller). a<<k never overflows because gcd ≤ min nonzero operand. k ≤ NBITS−1.
- Zero can only come from the inputs. Rules 7/8 never produce 0, because equal operands terminate first via rule 3.

## Timing
- Reset (asynchronous, any state including mid-RUN): state=IDLE, in_ready=1, out_valid=0, result=0, cycles=0, internal a/b/k/cnt=0. Any in-flight operation is discarded.
- Latency: operands accepted at edge T. RUN occupies edges T+1 … T+cycles. out_valid is high from T+cycles until the edge where out_ready=1 is sampled.
- Minimum occupancy is 3 cycles (IDLE→RUN→DONE→IDLE). No back-to-back acceptance: in_ready is low in RUN and DONE.
- out_valid and out_ready both high: result consumed, IDLE on the next edge, and in_ready=1 from then on.
- in_valid while not ready: ignored. The producer must hold its operands, and nothing is captured.
- out_ready asserted outside DONE: no effect.
- Worst case cycles ≤ 2·NBITS; the counter never wraps.

## Structure
- Package gcd_pkg contains:
  - the state enum typedef gcd_state_t {IDLE, RUN, DONE}
  - localparam defaults for NBITS
  - a function computing CNT_W.
- Sub-module gcd_stein_step: a purely combinational single-step datapath. Inputs are a, b, k. Outputs are next a, b, k, a term flag and the term result. The top level holds the FSM, registers, counters and handshake.

## Test plan
- a=48, b=18 → result=6, cycles=6, out_valid 6 cycles after acceptance edge.
- a=0, b=35 → result=35, cycles=1. a=0, b=0 → result=0, cycles=1. a=7, b=7 → result=7, cycles=1.
- a=2^NBITS−1, b=2^NBITS−2 → result=1. Also check cycles ≤ 2·NBITS.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result/cycles stable, in_ready=0, and in_valid pulses with new operands ignored. Then raise out_ready and check in_ready=1 on the next cycle.
- Reset mid-RUN (a=1024, b=768, reset_n low on the 3rd RUN cycle) → immediately IDLE with all outputs 0. A new op a=12, b=8 then gives result=4.
- Random: 10k random operand pairs, including zeros and powers of two, checked against a reference GCD model with random out_ready stalls.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the binary (Stein) GCD engine.
package gcd_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  // Default operand/result width.
  localparam int NBITS_DEFAULT = 32;

  // Step counter width: worst case is 2*nbits steps, so 2*nbits+1 values
  // must fit without the counter wrapping.
  function automatic int cnt_width(input int nbits);
    return $clog2(2 * nbits + 2);
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational Stein GCD step: picks the first matching rule for the
// current (a, b, k) and produces the next operands or the final result.
module gcd_stein_step
  import gcd_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int K_W   = $clog2(NBITS + 1)
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [K_W-1:0]   k,
  output logic [NBITS-1:0] a_next,
  output logic [NBITS-1:0] b_next,
  output logic [K_W-1:0]   k_next,
  output logic             term,
  output logic [NBITS-1:0] term_result
);

  // Rule priority chain; the final else covers "both odd, a < b".
  always_comb begin
    a_next      = a;
    b_next      = b;
    k_next      = k;
    term        = 1'b0;
    term_result = '0;
    if (a == '0) begin
      term        = 1'b1;
      term_result = b << k;
    end else if (b == '0) begin
      term        = 1'b1;
      term_result = a << k;
    end else if (a == b) begin
      term        = 1'b1;
      term_result = a << k;
    end else if (!a[0] && !b[0]) begin
      a_next = a >> 1;
      b_next = b >> 1;
      k_next = k + K_W'(1);
    end else if (!a[0]) begin
      a_next = a >> 1;
    end else if (!b[0]) begin
      b_next = b >> 1;
    end else if (a > b) begin
      a_next = (a - b) >> 1;
    end else begin
      b_next = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein.sv
// Binary GCD engine with valid/ready handshakes on both sides. Holds the
// IDLE/RUN/DONE control, operand registers, step counter and output latch;
// the per-step arithmetic lives in gcd_stein_step.
module gcd_stein
  import gcd_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int CNT_W = cnt_width(NBITS),
  parameter int K_W   = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a_in,
  input  logic [NBITS-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] result,
  output logic [CNT_W-1:0] cycles
);

  gcd_state_t       state_r, state_s;
  logic [NBITS-1:0] a_r, b_r;
  logic [K_W-1:0]   k_r;
  logic [CNT_W-1:0] cnt_r;
  logic [NBITS-1:0] result_r;
  logic [CNT_W-1:0] cycles_r;
  logic             in_ready_r, out_valid_r;
  logic             capture_s, step_s;

  logic [NBITS-1:0] a_next_s, b_next_s, term_result_s;
  logic [K_W-1:0]   k_next_s;
  logic             term_s;

  gcd_stein_step #(
    .NBITS (NBITS),
    .K_W   (K_W)
  ) u_step (
    .a           (a_r),
    .b           (b_r),
    .k           (k_r),
    .a_next      (a_next_s),
    .b_next      (b_next_s),
    .k_next      (k_next_s),
    .term        (term_s),
    .term_result (term_result_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus capture/step strobes for the datapath.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    step_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          capture_s = 1'b1;
          state_s   = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (term_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand, step-count and result registers; result/cycles only change on
  // the terminating RUN cycle so they stay stable throughout DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r      <= '0;
      b_r      <= '0;
      k_r      <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      cycles_r <= '0;
    end else if (capture_s) begin
      a_r   <= a_in;
      b_r   <= b_in;
      k_r   <= '0;
      cnt_r <= '0;
    end else if (step_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (term_s) begin
        result_r <= term_result_s;
        cycles_r <= cnt_r + CNT_W'(1);
      end else begin
        a_r <= a_next_s;
        b_r <= b_next_s;
        k_r <= k_next_s;
      end
    end else begin
      a_r <= a_r;
    end
  end

  // Handshake flags registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cycles    = cycles_r;

endmodule
